run_sequencer: RTL and testbench

- Front-end controller for the single-cycle datapath.
- Streams a program into the instruction cache through the datapath's programming port (prog/blockAddr/Iword), forces the entry PC via loadPC/initPC, then lets the core run for a bounded number of cycles.
- Stops early on an ALU overflow trap or an external abort, and reports completion status and the executed-cycle count.
- Sits between the testbench/host loader and the datapath top level.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_load_pipe.sv | 60 ++++++
 rtl/run_sequencer.sv | 146 ++++++++++++++
 tb/tb_run_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the run sequencer: FSM states and completion status codes.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_SETPC = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_LIMIT = 2'd0,
    ST_OVFL  = 2'd1,
    ST_ABORT = 2'd2
  } status_e;

endpackage

// File: rtl/seq_load_pipe.sv
// Loader-to-icache write stage: accepts words, registers them, and drives the
// programming port one cycle after each accept.
module seq_load_pipe #(
  parameter int N  = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [AW:0]   len_i,
  input  logic          en_i,
  input  logic          abort_i,
  input  logic          ld_valid_i,
  input  logic [N-1:0]  ld_data_i,
  output logic          ld_ready_o,
  output logic          last_o,
  output logic          prog_o,
  output logic [AW-1:0] blockAddr_o,
  output logic [N-1:0]  Iword_o
);

  logic [AW:0]   cnt_q, cnt_d, len_q;
  logic          pend_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  word_q;
  logic          xfer;

  assign ld_ready_o = en_i && !abort_i && (cnt_q < len_q);
  assign xfer       = ld_valid_i && ld_ready_o;
  assign cnt_d      = cnt_q + (AW+1)'(1);
  assign last_o     = xfer && (cnt_d == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      len_q  <= '0;
      pend_q <= 1'b0;
      addr_q <= '0;
      word_q <= '0;
    end else begin
      pend_q <= xfer;
      if (clr_i) begin
        cnt_q <= '0;
        len_q <= len_i;
      end else if (xfer) begin
        cnt_q <= cnt_d;
      end
      // Low AW bits of the count are the write pointer; it wraps only after a full image.
      if (xfer) begin
        addr_q <= cnt_q[AW-1:0];
        word_q <= ld_data_i;
      end
    end
  end

  assign prog_o      = pend_q;
  assign blockAddr_o = addr_q;
  assign Iword_o     = word_q;

endmodule

// File: rtl/run_sequencer.sv
// Front-end controller: loads a program into the icache, forces the entry PC,
// then runs the core for a bounded number of cycles with overflow/abort stops.
module run_sequencer
  import seq_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 7,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   prog_len,
  input  logic [29:0]   entry_pc,
  input  logic [CW-1:0] max_cycles,
  input  logic          trap_ovfl,
  input  logic          ld_valid,
  input  logic [N-1:0]  ld_data,
  output logic          ld_ready,
  input  logic [1:0]    flag,
  output logic          prog,
  output logic          loadPC,
  output logic [29:0]   initPC,
  output logic [AW-1:0] blockAddr,
  output logic [N-1:0]  Iword,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [CW-1:0] cycles_run
);

  state_e        state_q, state_d;
  status_e       stat_q, stat_d;
  logic [29:0]   initpc_q, initpc_d;
  logic [CW-1:0] max_q, max_d;
  logic [CW-1:0] cyc_q, cyc_d, cyc_inc;
  logic          clr, last;
  logic          unused_flag;

  assign unused_flag = flag[1];
  assign cyc_inc     = cyc_q + CW'(1);

  seq_load_pipe #(.N(N), .AW(AW)) u_load (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .len_i       (prog_len),
    .en_i        (state_q == S_LOAD),
    .abort_i     (abort),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_ready_o  (ld_ready),
    .last_o      (last),
    .prog_o      (prog),
    .blockAddr_o (blockAddr),
    .Iword_o     (Iword)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stat_q   <= ST_LIMIT;
      initpc_q <= '0;
      max_q    <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      initpc_q <= initpc_d;
      max_q    <= max_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    initpc_d = initpc_q;
    max_d    = max_q;
    cyc_d    = cyc_q;
    clr      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr      = 1'b1;
          initpc_d = entry_pc;
          max_d    = max_cycles;
          cyc_d    = '0;
          state_d  = (prog_len == '0) ? S_SETPC : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_DONE;
          stat_d  = ST_ABORT;
        end else if (last) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d = S_DONE;
          stat_d  = ST_ABORT;
        end else begin
          state_d = S_SETPC;
        end
      end
      S_SETPC: begin
        if (abort) begin
          state_d = S_DONE;
          stat_d  = ST_ABORT;
        end else if (max_q == '0) begin
          state_d = S_DONE;
          stat_d  = ST_LIMIT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Every RUN cycle counts, including the one that terminates the run.
        if (cyc_q != max_q) cyc_d = cyc_inc;
        if (abort) begin
          state_d = S_DONE;
          stat_d  = ST_ABORT;
        end else if (trap_ovfl && flag[0]) begin
          state_d = S_DONE;
          stat_d  = ST_OVFL;
        end else if (cyc_inc == max_q) begin
          state_d = S_DONE;
          stat_d  = ST_LIMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign loadPC     = (state_q != S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH) ||
                      (state_q == S_SETPC) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign initPC     = initpc_q;
  assign status     = stat_q;
  assign cycles_run = cyc_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: table of directed jobs plus randomized jobs, each
// checked against a job-level model of writes, run length and exit status.
module tb_run_sequencer;

  localparam int N  = 32;
  localparam int AW = 7;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, trap_ovfl, ld_valid;
  logic [AW:0]   prog_len;
  logic [29:0]   entry_pc;
  logic [CW-1:0] max_cycles;
  logic [N-1:0]  ld_data;
  logic [1:0]    flag;
  logic          ld_ready, prog, loadPC, busy, done;
  logic [29:0]   initPC;
  logic [AW-1:0] blockAddr;
  logic [N-1:0]  Iword;
  logic [1:0]    status;
  logic [CW-1:0] cycles_run;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_sequencer #(.N(N), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
    .entry_pc(entry_pc), .max_cycles(max_cycles), .trap_ovfl(trap_ovfl),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .flag(flag),
    .prog(prog), .loadPC(loadPC), .initPC(initPC), .blockAddr(blockAddr),
    .Iword(Iword), .busy(busy), .done(done), .status(status), .cycles_run(cycles_run)
  );

  // vmode: 0 continuous valid, 1 toggling 1,0,1,0, 2 random
  // abort_w: abort once this many words are accepted (-1 never)
  // abort_r / ovfl_at: RUN cycle index (1-based) of abort / flag[0] rise (0 never)
  typedef struct {
    int len; int epc; int maxc; bit trap; int ovfl_at;
    int abort_w; int abort_r; int vmode; int exp_st; int exp_cyc;
  } job_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Job-level reference: outcome from the abort/overflow/budget rules alone.
  function automatic void model(input job_t j, output int st, output int cyc, output int nwr);
    st = 0; cyc = 0; nwr = j.len;
    if (j.abort_w >= 0 && j.abort_w < j.len) begin
      st = 2; nwr = j.abort_w;
      return;
    end
    for (int c = 1; c <= j.maxc; c++) begin
      cyc = c;
      if (c == j.abort_r) begin st = 2; return; end
      if (j.trap && j.ovfl_at > 0 && c >= j.ovfl_at) begin st = 1; return; end
      if (c == j.maxc) begin st = 0; return; end
    end
  endfunction

  task automatic run_job(input job_t j, input string nm);
    logic [N-1:0] words[$];
    logic [N-1:0] plan[4];
    int st, cyc, nwr, acc, wr, runc, n;
    bit prev_x, fin;
    plan[0] = 32'h20010005; plan[1] = 32'h20020003;
    plan[2] = 32'h00221820; plan[3] = 32'h08000000;
    for (int i = 0; i < j.len; i++) words.push_back(j.len == 4 ? plan[i] : $urandom);
    model(j, st, cyc, nwr);
    if (j.exp_st >= 0) begin
      chk({nm, " model_status"}, 64'(st), 64'(j.exp_st));
      chk({nm, " model_cycles"}, 64'(cyc), 64'(j.exp_cyc));
    end
    acc = 0; wr = 0; runc = 0; prev_x = 0; fin = 0;
    @(posedge clk); #1;
    start = 1; prog_len = (AW+1)'(j.len); entry_pc = 30'(j.epc);
    max_cycles = CW'(j.maxc); trap_ovfl = j.trap;
    @(posedge clk); #1;
    start = 0;
    for (n = 0; n < 3000; n++) begin
      ld_valid = (acc < j.len) && (j.vmode == 0 || (j.vmode == 1 && n % 2 == 0) ||
                                   (j.vmode == 2 && $urandom_range(1) == 1));
      ld_data  = (acc < j.len) ? words[acc] : '0;
      abort    = busy && loadPC && acc < j.len && acc == j.abort_w;
      flag     = {1'($urandom), 1'b0};
      if (!loadPC) begin
        if (j.ovfl_at > 0 && runc + 1 >= j.ovfl_at) flag[0] = 1'b1;
        if (runc + 1 == j.abort_r) abort = 1'b1;
      end
      @(negedge clk);
      if (done) begin fin = 1; break; end
      chk({nm, " prog_after_accept"}, 64'(prog), 64'(prev_x));
      if (abort) chk({nm, " ready_on_abort"}, 64'(ld_ready), 64'(0));
      if (prog) begin
        if (wr < nwr) begin
          chk({nm, " wr_addr"}, 64'(blockAddr), 64'(wr % (1 << AW)));
          chk({nm, " wr_data"}, 64'(Iword), 64'(words[wr]));
        end
        wr++;
      end
      prev_x = ld_valid && ld_ready;
      if (prev_x) acc++;
      if (!loadPC) runc++;
      @(posedge clk); #1;
    end
    chk({nm, " finished"}, 64'(fin), 64'(1));
    abort = 0; ld_valid = 0; flag = '0;
    chk({nm, " writes"}, 64'(wr), 64'(nwr));
    chk({nm, " run_cycles"}, 64'(runc), 64'(cyc));
    chk({nm, " status"}, 64'(status), 64'(st));
    chk({nm, " cycles_run"}, 64'(cycles_run), 64'(cyc));
    chk({nm, " busy"}, 64'(busy), 64'(0));
    chk({nm, " initPC"}, 64'(initPC), 64'(j.epc));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " loadPC"}, 64'(loadPC), 64'(1));
    chk({nm, " busy"}, 64'(busy), 64'(0));
    chk({nm, " done"}, 64'(done), 64'(0));
    chk({nm, " cycles_run"}, 64'(cycles_run), 64'(0));
    chk({nm, " prog"}, 64'(prog), 64'(0));
    chk({nm, " ld_ready"}, 64'(ld_ready), 64'(0));
    chk({nm, " initPC"}, 64'(initPC), 64'(0));
    chk({nm, " status"}, 64'(status), 64'(0));
    chk({nm, " blockAddr"}, 64'(blockAddr), 64'(0));
    chk({nm, " Iword"}, 64'(Iword), 64'(0));
  endtask

  initial begin
    job_t tbl[$];
    job_t r;
    int st, cyc, nwr;
    rst = 1; start = 0; abort = 0; trap_ovfl = 0; ld_valid = 0; ld_data = '0;
    prog_len = '0; entry_pc = '0; max_cycles = '0; flag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_state("reset");

    //        len epc  maxc trap ovfl abw abr vm  st cyc
    tbl.push_back('{4,   0,  10, 0,   0,  -1, 0,  0,  0, 10});
    tbl.push_back('{4,   0,  10, 0,   0,  -1, 0,  1,  0, 10});
    tbl.push_back('{0,   5,   3, 0,   0,  -1, 0,  0,  0,  3});
    tbl.push_back('{4,   0,  10, 1,   3,  -1, 0,  0,  1,  3});
    tbl.push_back('{4,   0,  10, 0,   3,  -1, 0,  0,  0, 10});
    tbl.push_back('{5,   0,  10, 0,   0,   2, 0,  0,  2,  0});
    tbl.push_back('{5,   7,   6, 0,   0,  -1, 0,  0,  0,  6});
    tbl.push_back('{3,   1,   0, 0,   0,  -1, 0,  0,  0,  0});
    tbl.push_back('{2,   2,   8, 1,   4,  -1, 4,  1,  2,  4});
    tbl.push_back('{1,   9,   1, 1,   1,  -1, 0,  0,  1,  1});
    tbl.push_back('{128, 3,   2, 0,   0,  -1, 0,  0,  0,  2});
    tbl.push_back('{4,   0,  10, 0,   0,   0, 0,  0,  2,  0});
    foreach (tbl[i]) run_job(tbl[i], $sformatf("tbl%0d", i));

    for (int k = 0; k < 40; k++) begin
      r.len     = ($urandom_range(9) == 0) ? 128 : int'($urandom_range(8));
      r.epc     = int'($urandom_range(30'h3FFFFFFF));
      r.maxc    = int'($urandom_range(20));
      r.trap    = 1'($urandom);
      r.ovfl_at = int'($urandom_range(r.maxc + 2));
      r.abort_w = ($urandom_range(3) == 0) ? int'($urandom_range(r.len)) : -1;
      r.abort_r = ($urandom_range(3) == 0) ? int'($urandom_range(r.maxc)) : 0;
      r.vmode   = int'($urandom_range(2));
      r.exp_st  = -1; r.exp_cyc = 0;
      model(r, st, cyc, nwr);
      run_job(r, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of a run returns everything to the reset state.
    @(posedge clk); #1;
    start = 1; prog_len = '0; entry_pc = 30'd11; max_cycles = CW'(50); trap_ovfl = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrun loadPC", 64'(loadPC), 64'(0));
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk_reset_state("midrun_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
